keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Scans a 4x4 active-low key matrix for the alarm clock's time/alarm entry.
//  - Drives one-hot active-low column strobes in the same order as the display
//    digit strobes.
//  - Reads the pulled-up row lines and debounces whole scan frames.
//  - Emits a 4-bit key code with a one-cycle valid pulse per debounced press.
//  - Sits between the keypad pins and the alarm-setting control FSM.
// PARAMETERS
//  SCAN_DIV      16'd1000  clk cycles each column is strobed; must be >= 4
//  DEBOUNCE_CNT  8'd4      consecutive identical frames needed to accept a press or a release; must be >= 1
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  row_n      in   4  raw keypad rows; 0 = key closed on the strobed column; asynchronous to clk
//  col_n      out  4  column strobes, active-low one-hot: idx0=1110, idx1=1101, idx2=1011, idx3=0111
//  key_code   out  4  {col_idx[1:0], row_idx[1:0]} of the accepted key; row_idx = bit position of the low row
//  key_valid  out  1  one-cycle pulse when a new key is accepted; key_code is valid in the same cycle
//  key_held   out  1  high from acceptance until the debounced release
// BEHAVIOUR
//  Reset: col_n=1110, key_code=0, key_valid=0, key_held=0, FSM=IDLE, all counters=0, sync flops=1111.
//  Input synchronisation:
//  - row_n passes through a 2-flop synchroniser; only the synced value is used.
//  Scan timing:
//  - div_cnt counts 0..SCAN_DIV-1 and wraps.
//  - On div_cnt==SCAN_DIV-1: sample the synced rows for the current column, then advance col_idx (3 wraps to 0).
//  - col_n changes on the following edge.
//  - Settling plus sync latency fits because SCAN_DIV >= 4.
//  Frame evaluation, once per frame at the sample of col_idx 3:
//  - Four column samples are accumulated.
//  - frame class: NONE (no zeros), ONE (exactly one zero across all 16 bits; yields code), MULTI (>=2 zeros).
//  FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE; transitions happen only at frame ends.
//  - IDLE: ONE -> DEBOUNCE, cand=code, cnt=1. NONE or MULTI -> stay.
//  - DEBOUNCE:
//    - ONE with code==cand: cnt+1; on reaching DEBOUNCE_CNT -> PRESSED, key_code=cand, key_valid=1 for 1 cycle.
//    - ONE with a different code: cand=code, cnt=1.
//    - NONE or MULTI -> IDLE.
//  - PRESSED: key_held=1.
//    - NONE -> RELEASE, cnt=1; if DEBOUNCE_CNT==1, go straight to IDLE.
//    - ONE or MULTI -> stay. No rollover: no new key_valid while a key is held.
//  - RELEASE:
//    - NONE: cnt+1; on reaching DEBOUNCE_CNT -> IDLE, key_held=0.
//    - ONE or MULTI -> PRESSED, with no new key_valid.
//  DEBOUNCE_CNT==1: an accepted ONE frame from IDLE goes directly to PRESSED.
//  Latency: a stable press is accepted at the end of frame number DEBOUNCE_CNT after the first frame that sees it.
//  key_code holds its value until the next acceptance; it is not cleared on release.
//  Reset asserted mid-scan or mid-debounce: everything returns to reset values immediately, with no pulse on exit.
//  Counter widths: div_cnt is 16 bits and the debounce counter is 8 bits; neither may overflow for legal parameters.
// STRUCTURE
//  Shared package / include keypad_defs:
//  - FSM state encodings (2 bits).
//  - Frame-class constants NONE/ONE/MULTI.
//  - Key code width (4).
//  Sub-module row_sync: a 2-flop, 4-bit synchroniser with a set-to-1 asynchronous reset.
//  Everything else lives in keypad_scan:
//  - divider
//  - column counter and strobe decode
//  - frame accumulator
//  - debounce FSM
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_CNT=3, so one frame = 16 clk)
//  1. Reset, then idle rows=1111 -> col_n cycles 1110,1101,1011,0111, each for 4 clk; key_valid never asserts.
//  2. Hold key col2/row1: row_n=1101 while col_n=1011, else 1111 -> exactly one key_valid pulse with key_code=4'b1001
//     at the end of frame 3; key_held stays 1 while held.
//  3. Release after scenario 2 -> key_held drops at the end of the 3rd empty frame; key_code stays 1001; no key_valid.
//  4. Bounce: the key is present for 2 frames, absent for 1, then present for 3 -> a single key_valid
//     at the end of the 3rd frame of the last run; no earlier pulse.
//  5. Two keys (col0/row0 and col3/row3) held together from IDLE -> no key_valid. While PRESSED on key 0,
//     pressing key 15 as well -> no second pulse.
//  6. Assert rst_n=0 during DEBOUNCE (after 2 good frames) -> outputs return to reset values at once.
//     After release, the press needs 3 fresh frames before key_valid.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, frame
// classification and the per-frame decode of the 16 sampled key contacts.
package keypad_scan_pkg;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned COL_W   = 4;
    localparam int unsigned FRAME_W = ROW_W * COL_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_ONE   = 2'd1,
        FR_MULTI = 2'd2
    } frame_cls_t;

    typedef struct packed {
        frame_cls_t        cls;
        logic [KEY_W-1:0]  code;
    } frame_res_t;

    // Active-low one-hot strobe for a column index.
    function automatic logic [COL_W-1:0] col_strobe(input logic [1:0] idx);
        return ~(COL_W'(1) << idx);
    endfunction

    // Bit i of a frame is key {col,row} = i; count zeros saturating at two.
    function automatic frame_res_t classify(input logic [FRAME_W-1:0] bits);
        frame_res_t res;
        logic [1:0] zeros;
        res.cls  = FR_NONE;
        res.code = '0;
        zeros    = 2'd0;
        for (int i = 0; i < int'(FRAME_W); i++) begin
            if (!bits[i]) begin
                if (zeros == 2'd0) res.code = KEY_W'(i);
                if (zeros != 2'd2) zeros = zeros + 2'd1;
            end
        end
        case (zeros)
            2'd0:    res.cls = FR_NONE;
            2'd1:    res.cls = FR_ONE;
            default: res.cls = FR_MULTI;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines; resets to
// all-ones so an idle (pulled-up) keypad is seen during and after reset.
module keypad_scan_row_sync
    import keypad_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROW_W-1:0] d,
    output logic [ROW_W-1:0] q
);

    logic [ROW_W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: strobes columns, accumulates one frame of row samples
// and debounces whole frames into a single key_valid pulse per press.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV     = 16'd1000,
    parameter logic [7:0]  DEBOUNCE_CNT = 8'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROW_W-1:0] row_n,
    output logic [COL_W-1:0] col_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    logic [ROW_W-1:0]          rows;
    logic [15:0]               div_cnt;
    logic [1:0]                col_idx;
    logic [FRAME_W-ROW_W-1:0]  acc;
    logic                      sample;
    logic                      frame_end;
    frame_res_t                res;
    state_t                    state;
    logic [KEY_W-1:0]          cand;
    logic [7:0]                db_cnt;
    logic [7:0]                db_next;
    logic                      db_done;

    keypad_scan_row_sync u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (rows)
    );

    assign sample    = (div_cnt == SCAN_DIV - 16'd1);
    assign frame_end = sample && (col_idx == 2'd3);
    assign res       = classify({rows, acc});
    assign db_next   = db_cnt + 8'd1;
    assign db_done   = (db_next == DEBOUNCE_CNT);

    // Divider, column sequencing and accumulation of columns 0..2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 16'd0;
            col_idx <= 2'd0;
            col_n   <= col_strobe(2'd0);
            acc     <= '1;
        end else if (sample) begin
            div_cnt <= 16'd0;
            col_idx <= col_idx + 2'd1;
            col_n   <= col_strobe(col_idx + 2'd1);
            case (col_idx)
                2'd0:    acc[3:0]  <= rows;
                2'd1:    acc[7:4]  <= rows;
                2'd2:    acc[11:8] <= rows;
                default: ;
            endcase
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Debounce FSM; it only moves at frame ends, key_valid is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cand      <= '0;
            db_cnt    <= 8'd0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    ST_IDLE: begin
                        if (res.cls == FR_ONE) begin
                            if (DEBOUNCE_CNT == 8'd1) begin
                                state     <= ST_PRESSED;
                                key_code  <= res.code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                db_cnt    <= 8'd0;
                            end else begin
                                state  <= ST_DEBOUNCE;
                                cand   <= res.code;
                                db_cnt <= 8'd1;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (res.cls == FR_ONE) begin
                            if (res.code != cand) begin
                                cand   <= res.code;
                                db_cnt <= 8'd1;
                            end else if (db_done) begin
                                state     <= ST_PRESSED;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                db_cnt    <= 8'd0;
                            end else begin
                                db_cnt <= db_next;
                            end
                        end else begin
                            state  <= ST_IDLE;
                            db_cnt <= 8'd0;
                        end
                    end
                    ST_PRESSED: begin
                        if (res.cls == FR_NONE) begin
                            if (DEBOUNCE_CNT == 8'd1) begin
                                state    <= ST_IDLE;
                                key_held <= 1'b0;
                                db_cnt   <= 8'd0;
                            end else begin
                                state  <= ST_RELEASE;
                                db_cnt <= 8'd1;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (res.cls == FR_NONE) begin
                            if (db_done) begin
                                state    <= ST_IDLE;
                                key_held <= 1'b0;
                                db_cnt   <= 8'd0;
                            end else begin
                                db_cnt <= db_next;
                            end
                        end else begin
                            state  <= ST_PRESSED;
                            db_cnt <= 8'd0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        db_cnt <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3 (16 clk per frame);
// a behavioural keypad drives row_n from col_n and the set of closed keys.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int base   = 0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV     (16'd4),
        .DEBOUNCE_CNT (8'd3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Key {col,row} = bit col*4+row of keys pulls its row low while its column is strobed.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_n[c]) row_n = row_n & ~keys[c*4 +: 4];
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) pulses++;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        keys  = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_col_n", 16'(col_n), 16'h000E);
        check_eq("rst_key_code", 16'(key_code), 16'h0000);
        check_eq("rst_key_valid", 16'(key_valid), 16'h0000);
        check_eq("rst_key_held", 16'(key_held), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: idle scan sequence
        wait_cycles(2);  check_eq("scan_col0", 16'(col_n), 16'h000E);
        wait_cycles(4);  check_eq("scan_col1", 16'(col_n), 16'h000D);
        wait_cycles(4);  check_eq("scan_col2", 16'(col_n), 16'h000B);
        wait_cycles(4);  check_eq("scan_col3", 16'(col_n), 16'h0007);
        wait_cycles(2);
        wait_cycles(32); check_eq("idle_pulses", 16'(pulses), 16'd0);

        // 2: press col2/row1, accepted at end of third frame
        keys = 16'h0200;
        wait_cycles(47);
        check_eq("press_early_valid", 16'(key_valid), 16'h0000);
        check_eq("press_early_pulses", 16'(pulses), 16'd0);
        wait_cycles(1);
        check_eq("press_valid", 16'(key_valid), 16'h0001);
        check_eq("press_code", 16'(key_code), 16'h0009);
        check_eq("press_held", 16'(key_held), 16'h0001);
        wait_cycles(32);
        check_eq("hold_held", 16'(key_held), 16'h0001);
        check_eq("hold_pulses", 16'(pulses), 16'd1);

        // 3: release, held drops at end of third empty frame
        keys = 16'h0000;
        wait_cycles(47);
        check_eq("release_early_held", 16'(key_held), 16'h0001);
        wait_cycles(1);
        check_eq("release_held", 16'(key_held), 16'h0000);
        check_eq("release_code", 16'(key_code), 16'h0009);
        check_eq("release_pulses", 16'(pulses), 16'd1);

        // 4: bounce 2 present / 1 absent / 3 present
        base = pulses;
        keys = 16'h0200; wait_cycles(32);
        keys = 16'h0000; wait_cycles(16);
        keys = 16'h0200; wait_cycles(47);
        check_eq("bounce_early_pulses", 16'(pulses - base), 16'd0);
        wait_cycles(1);
        check_eq("bounce_valid", 16'(key_valid), 16'h0001);
        check_eq("bounce_pulses", 16'(pulses - base), 16'd1);
        keys = 16'h0000; wait_cycles(48);
        check_eq("bounce_release_held", 16'(key_held), 16'h0000);

        // 6: reset during DEBOUNCE, 5 cycles into the third frame (column 1 strobed)
        base = pulses;
        keys = 16'h0200;
        wait_cycles(37);
        check_eq("pre_rst_col_n", 16'(col_n), 16'h000D);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_col_n", 16'(col_n), 16'h000E);
        check_eq("mid_rst_code", 16'(key_code), 16'h0000);
        check_eq("mid_rst_valid", 16'(key_valid), 16'h0000);
        check_eq("mid_rst_held", 16'(key_held), 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(47);
        check_eq("post_rst_early_pulses", 16'(pulses - base), 16'd0);
        wait_cycles(1);
        check_eq("post_rst_valid", 16'(key_valid), 16'h0001);
        check_eq("post_rst_code", 16'(key_code), 16'h0009);
        keys = 16'h0000; wait_cycles(48);
        check_eq("post_rst_release_held", 16'(key_held), 16'h0000);

        // 5: two keys from IDLE, then no rollover while held
        base = pulses;
        keys = 16'h8001; wait_cycles(64);
        check_eq("multi_pulses", 16'(pulses - base), 16'd0);
        check_eq("multi_held", 16'(key_held), 16'h0000);
        keys = 16'h0001; wait_cycles(47);
        check_eq("key0_early_valid", 16'(key_valid), 16'h0000);
        wait_cycles(1);
        check_eq("key0_valid", 16'(key_valid), 16'h0001);
        check_eq("key0_code", 16'(key_code), 16'h0000);
        keys = 16'h8001; wait_cycles(48);
        check_eq("rollover_pulses", 16'(pulses - base), 16'd1);
        check_eq("rollover_held", 16'(key_held), 16'h0001);
        check_eq("rollover_code", 16'(key_code), 16'h0000);
        keys = 16'h0000; wait_cycles(48);
        check_eq("final_held", 16'(key_held), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
